// File: rtl/rf_xchg_seq_pkg.sv
// Shared definitions for the Z80 register-exchange sequencer: register-file
// IDs (same encoding as the register file), op codes and FSM states.
package rf_xchg_seq_pkg;

    localparam int RID_W_C = 5;

    // Register-file pair IDs; R0 is the discard target for writes.
    localparam logic [4:0] RID_R0  = 5'd0;
    localparam logic [4:0] RID_AF  = 5'd1;
    localparam logic [4:0] RID_BC  = 5'd2;
    localparam logic [4:0] RID_DE  = 5'd3;
    localparam logic [4:0] RID_HL  = 5'd4;
    localparam logic [4:0] RID_AFS = 5'd5;
    localparam logic [4:0] RID_BCS = 5'd6;
    localparam logic [4:0] RID_DES = 5'd7;
    localparam logic [4:0] RID_HLS = 5'd8;
    localparam logic [4:0] RID_T10 = 5'd9;
    localparam logic [4:0] RID_T32 = 5'd10;

    typedef enum logic [1:0] {
        OP_EX_DE_HL  = 2'd0,
        OP_EX_AF_AFS = 2'd1,
        OP_EXX       = 2'd2,
        OP_ILLEGAL   = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SAVE    = 2'd1,
        ST_MOVE    = 2'd2,
        ST_RESTORE = 2'd3
    } state_e;

    // True for the three real exchange instructions.
    function automatic logic op_is_legal(input logic [1:0] op);
        return (op != OP_ILLEGAL);
    endfunction

    // Width of a counter that indexes n pairs (at least one bit).
    function automatic int pcnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rf_xchg_seq_pair_rom.sv
// Pair table for the exchange sequencer: maps (op, pair index) to the two
// register IDs being swapped and flags the final pair of the operation.
// The illegal op maps to R0/R0 so a NOP pass never touches real registers.
module rf_xchg_pair_rom
    import rf_xchg_seq_pkg::*;
#(
    parameter int RID_W  = 5,
    parameter int PCNT_W = 2
) (
    input  logic [1:0]        op,
    input  logic [PCNT_W-1:0] pair_idx,
    output logic [RID_W-1:0]  x_id,
    output logic [RID_W-1:0]  y_id,
    output logic              last
);

    // Table lookup; unused index/op combinations fall back to R0 and last.
    always_comb begin
        x_id = RID_R0;
        y_id = RID_R0;
        last = 1'b1;
        case (op)
            OP_EX_DE_HL: begin
                x_id = RID_DE;
                y_id = RID_HL;
                last = 1'b1;
            end
            OP_EX_AF_AFS: begin
                x_id = RID_AF;
                y_id = RID_AFS;
                last = 1'b1;
            end
            OP_EXX: begin
                if (pair_idx == PCNT_W'(0)) begin
                    x_id = RID_BC;
                    y_id = RID_BCS;
                    last = 1'b0;
                end else if (pair_idx == PCNT_W'(1)) begin
                    x_id = RID_DE;
                    y_id = RID_DES;
                    last = 1'b0;
                end else begin
                    x_id = RID_HL;
                    y_id = RID_HLS;
                    last = 1'b1;
                end
            end
            default: begin
                x_id = RID_R0;
                y_id = RID_R0;
                last = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/rf_xchg_seq.sv
// Z80 register-exchange sequencer (EX DE,HL / EX AF,AF' / EXX). Passes the
// pipeline's read-0/write requests through when idle; when busy it owns the
// register-file ports and swaps pairs via T32 in SAVE/MOVE/RESTORE steps.
// The written data is always the same-cycle read data, so nothing is stored.
// Optional macro RF_XCHG_ILLEGAL_TRAP_EN: op 3 raises a one-cycle 'illegal'
// pulse instead of running as a one-cycle NOP.
module rf_xchg_seq
    import rf_xchg_seq_pkg::*;
#(
    parameter int NPAIR_MAX = 3,
    parameter int RID_W     = 5
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             req_valid,
    input  logic [1:0]       req_op,
    output logic             req_ready,
    input  logic             hold,
    output logic             busy,
    output logic             done,
`ifdef RF_XCHG_ILLEGAL_TRAP_EN
    output logic             illegal,
`endif
    input  logic [RID_W-1:0] pipe_rd0_id,
    input  logic [RID_W-1:0] pipe_wr_id,
    input  logic [15:0]      pipe_wr_data,
    output logic             pipe_conflict,
    output logic [RID_W-1:0] rf_rd0_id,
    input  logic [15:0]      rf_rd_data0,
    output logic [RID_W-1:0] rf_wr_id,
    output logic [15:0]      rf_wr_data
);

    localparam int PCNT_W = pcnt_width(NPAIR_MAX);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [PCNT_W-1:0]   pair_q, pair_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                ready_q, ready_d;
    logic                illegal_q, illegal_d;

    logic [RID_W-1:0]    x_id_s;
    logic [RID_W-1:0]    y_id_s;
    logic                last_s;
    logic [RID_W-1:0]    wr_sel_s;

    rf_xchg_pair_rom #(
        .RID_W  (RID_W),
        .PCNT_W (PCNT_W)
    ) u_pair_rom (
        .op       (op_q),
        .pair_idx (pair_q),
        .x_id     (x_id_s),
        .y_id     (y_id_s),
        .last     (last_s)
    );

    // Next-state logic: accept in IDLE, step SAVE->MOVE->RESTORE per pair,
    // freeze everything while the pipeline holds.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        pair_d    = pair_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid && !hold) begin
`ifdef RF_XCHG_ILLEGAL_TRAP_EN
                    if (!op_is_legal(req_op)) begin
                        illegal_d = 1'b1;
                    end else begin
                        state_d = ST_SAVE;
                        op_d    = op_e'(req_op);
                        pair_d  = '0;
                    end
`else
                    state_d = ST_SAVE;
                    op_d    = op_e'(req_op);
                    pair_d  = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SAVE: begin
                if (hold) begin
                    state_d = ST_SAVE;
                end else if (!op_is_legal(op_q)) begin
                    // NOP pass for op 3: one busy cycle, then complete.
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_MOVE;
                end
            end
            ST_MOVE: begin
                if (hold) begin
                    state_d = ST_MOVE;
                end else begin
                    state_d = ST_RESTORE;
                end
            end
            ST_RESTORE: begin
                if (hold) begin
                    state_d = ST_RESTORE;
                end else if (last_s) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d = ST_SAVE;
                    pair_d  = pair_q + PCNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d  = (state_d != ST_IDLE);
        ready_d = (state_d == ST_IDLE);
    end

    // State, counter and registered status outputs; reset aborts any operation.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_EX_DE_HL;
            pair_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b1;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            pair_q    <= pair_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
            illegal_q <= illegal_d;
        end
    end

    // Port steering: pass-through in IDLE, pair-table driven while busy.
    always_comb begin
        rf_rd0_id  = pipe_rd0_id;
        wr_sel_s   = pipe_wr_id;
        rf_wr_data = pipe_wr_data;
        case (state_q)
            ST_IDLE: begin
                rf_rd0_id  = pipe_rd0_id;
                wr_sel_s   = pipe_wr_id;
                rf_wr_data = pipe_wr_data;
            end
            ST_SAVE: begin
                rf_rd0_id  = x_id_s;
                wr_sel_s   = op_is_legal(op_q) ? RID_T32 : RID_R0;
                rf_wr_data = rf_rd_data0;
            end
            ST_MOVE: begin
                rf_rd0_id  = y_id_s;
                wr_sel_s   = x_id_s;
                rf_wr_data = rf_rd_data0;
            end
            ST_RESTORE: begin
                rf_rd0_id  = RID_T32;
                wr_sel_s   = y_id_s;
                rf_wr_data = rf_rd_data0;
            end
            default: begin
                rf_rd0_id  = pipe_rd0_id;
                wr_sel_s   = pipe_wr_id;
                rf_wr_data = pipe_wr_data;
            end
        endcase
        // A held step must not commit its write; reads keep flowing.
        rf_wr_id = (hold && (state_q != ST_IDLE)) ? RID_R0 : wr_sel_s;
    end

    assign req_ready     = ready_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pipe_conflict = busy_q && (pipe_wr_id != RID_R0);

`ifdef RF_XCHG_ILLEGAL_TRAP_EN
    assign illegal = illegal_q;
`else
    logic unused_illegal_s;
    assign unused_illegal_s = illegal_q;
`endif

endmodule

// File: doc/rf_xchg_seq.md
Name: rf_xchg_seq

Overview:
Multi-cycle sequencer that performs Z80 register-exchange instructions (EX DE,HL; EX AF,AF'; EXX) on the register file through its single write port and read port 0.
- Sits between the decode/execute pipeline and the register file.
- When idle, it passes the pipeline's read-0/write requests straight through.
- When busy, it owns the ports and swaps 16-bit pairs using temporary pair T32 as scratch.

Parameters:
- NPAIR_MAX, 3, maximum number of pairs per operation; sizes the pair counter.
- RID_W, 5, register-ID width; must match the register-file ID encoding.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset; asynchronous, active-high
- req_valid  in  1  exchange request from decode
- req_op  in  2  0=EX DE,HL; 1=EX AF,AF'; 2=EXX; 3=illegal
- req_ready  out  1  high only in IDLE
- hold  in  1  pipeline stall; freezes the sequencer
- busy  out  1  high in any non-IDLE state
- done  out  1  one-cycle pulse when an operation completes
- pipe_rd0_id  in  5  pipeline read-0 ID (pass-through)
- pipe_wr_id  in  5  pipeline write ID (pass-through)
- pipe_wr_data  in  16  pipeline write data (pass-through)
- pipe_conflict  out  1  high when pipe_wr_id is not R0 while busy
- rf_rd0_id  out  5  to register file Rd0_id
- rf_rd_data0  in  16  from register file Rd_data0; forwarded, same-cycle
- rf_wr_id  out  5  to register file Wr_id
- rf_wr_data  out  16  to register file Wr_data

Behaviour:
- Reset values: state IDLE, pair counter 0, busy 0, done 0, req_ready 1. Register-ID outputs pass through pipe inputs.
- States: IDLE, SAVE, MOVE, RESTORE.
- Pair tables, indexed by the pair counter:
  - op0: (DE,HL)
  - op1: (AF,AFs)
  - op2: (BC,BCs), (DE,DEs), (HL,HLs)
- Pair (X,Y) port drive per state:
  - SAVE: rd0=X, wr_id=T32, wr_data=rf_rd_data0
  - MOVE: rd0=Y, wr_id=X, wr_data=rf_rd_data0
  - RESTORE: rd0=T32, wr_id=Y, wr_data=rf_rd_data0
- rf_wr_data is combinational from rf_rd_data0; no internal data storage. The register file's same-cycle forwarding makes each step correct.
- Transitions:
  - IDLE -> SAVE on req_valid & ~hold & (op != 3). Op and count are latched and the pair counter is cleared.
  - SAVE -> MOVE -> RESTORE.
  - RESTORE -> SAVE with pair counter +1 if more pairs remain; otherwise -> IDLE with done=1 registered. done is high in the first IDLE cycle.
- Latency from the accept edge: op0/op1 done at cycle 4 (3 active cycles); op2 done at cycle 10 (9 active cycles).
- hold=1 in SAVE/MOVE/RESTORE: state and counter frozen, rf_wr_id forced to R0, rd0 still driven.
- hold=1 in IDLE: the request is not accepted; pass-through continues.
- In IDLE, rf_* = pipe_*. A new request can be accepted in the same cycle done is high (back-to-back allowed).
- While busy, pipe_* is ignored. pipe_conflict is combinational: busy & (pipe_wr_id != R0).
- Flags are never written by this block; the parent ties the register file's Fmask to 0 while busy.
- Reset mid-operation: immediate IDLE, no done. The partially swapped registers and T32 are left as-is.

Optional Feature:
- Macro RF_XCHG_ILLEGAL_TRAP_EN.
- Defined: adds output illegal (1 bit). On req_valid & op==3 in IDLE, illegal pulses for one cycle (registered) and no state change occurs.
- Undefined: op==3 is accepted as a NOP. The block goes busy for one cycle with wr_id=R0, then pulses done; no illegal port exists.

Decomposition:
- Shared package: register-ID constants (R0, A..HLs, T10, T32, same encoding as the register file), op codes, state encoding.
- Natural sub-module: rf_xchg_pair_rom. Combinational (op, pair index) -> (X id, Y id, last-pair flag).

Test Plan:
- DE=1234, HL=ABCD; op0 -> rd/wr IDs DE/T32, HL/DE, T32/HL over 3 cycles; done at cycle 4; DE=ABCD, HL=1234.
- AF=5540, AFs=0001; op1 -> AF=0001, AFs=5540; busy high exactly 3 cycles.
- BC/DE/HL=1111/2222/3333, shadows=AAAA/BBBB/CCCC; op2 -> fully swapped; done at cycle 10. Repeat op2 -> original values restored.
- op2 with hold pulsed for 2 cycles during MOVE of pair 1 -> rf_wr_id=R0 while held; result as unheld; done at cycle 12.
- RST asserted asynchronously mid-op2 (pair 1, RESTORE) -> busy=0 immediately, no done; pass-through resumes next cycle.
- op==3 -> with macro: illegal pulse, busy stays 0. Without macro: busy 1 cycle, done, no register changes.
